// File: rtl/muldiv_unit_pkg.sv
// Shared op/state encodings and op-class helpers
// for the iterative multiply/divide engine.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MADD  = 3'd4,
    MD_OP_MADDU = 3'd5,
    MD_OP_MSUB  = 3'd6,
    MD_OP_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MD_ST_IDLE = 3'd0,
    MD_ST_MUL  = 3'd1,
    MD_ST_DIV  = 3'd2,
    MD_ST_FIX  = 3'd3,
    MD_ST_DONE = 3'd4
  } md_st_e;

  function automatic logic md_signed(md_op_e op);
    return op inside {MD_OP_MULT, MD_OP_DIV,
                      MD_OP_MADD, MD_OP_MSUB};
  endfunction

  function automatic logic md_div(md_op_e op);
    return op inside {MD_OP_DIV, MD_OP_DIVU};
  endfunction

  function automatic logic md_madd(md_op_e op);
    return op inside {MD_OP_MADD, MD_OP_MADDU};
  endfunction

  function automatic logic md_msub(md_op_e op);
    return op inside {MD_OP_MSUB, MD_OP_MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/ready bundle between the execute stage
// (master) and the multiply/divide engine (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic                   start_i;
  logic                   cancel_i;
  muldiv_unit_pkg::md_op_e op_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic [2*WIDTH-1:0]     acc_i;
  logic                   busy_o;
  logic                   ready_o;
  logic [2*WIDTH-1:0]     result_o;
  logic                   div_by_zero_o;

  modport master (
    output start_i, cancel_i, op_i,
    output opdata1_i, opdata2_i, acc_i,
    input  busy_o, ready_o, result_o,
    input  div_by_zero_o
  );

  modport slave (
    input  start_i, cancel_i, op_i,
    input  opdata1_i, opdata2_i, acc_i,
    output busy_o, ready_o, result_o,
    output div_by_zero_o
  );

endinterface

// File: rtl/muldiv_div_iter.sv
// Restoring divider datapath: one quotient bit
// per enabled cycle on unsigned magnitudes.
module muldiv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsor_d  = dsor_q;
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsor_q};
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dsor_d = divisor_i;
    end else if (en_i) begin
      // partial remainder < divisor, so diff fits
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for EX: magnitude
// datapath with sign/accumulate fix-up in FIX.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST =
    CW'(WIDTH / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(WIDTH - 1);

  md_st_e           state_q, state_d;
  md_op_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;
  logic [DW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [DW-1:0]    prod_q, prod_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [DW-1:0]    result_q, result_d;
  logic             dbz_q, dbz_d;

  md_op_e           in_op;
  logic             s1, s2, accept;
  logic             in_div, in_dz;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_load, div_en;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic [DW-1:0]    prod_s, fix_res;

  assign in_op  = bus.op_i;
  assign in_div = md_div(in_op);
  assign in_dz  = in_div && (bus.opdata2_i == '0);
  assign s1     = md_signed(in_op) & bus.opdata1_i[WIDTH-1];
  assign s2     = md_signed(in_op) & bus.opdata2_i[WIDTH-1];
  assign mag1   = s1 ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2   = s2 ? -bus.opdata2_i : bus.opdata2_i;
  assign accept = bus.start_i && !bus.cancel_i &&
                  (state_q == MD_ST_IDLE ||
                   state_q == MD_ST_DONE);
  assign div_load = accept && in_div;

  muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  always_comb begin
    prod_s  = neg_q ? -prod_q : prod_q;
    quo_s   = neg_q ? -quot : quot;
    rem_s   = rneg_q ? -rem : rem;
    fix_res = prod_s;
    if (md_div(op_q)) begin
      // divide-by-zero returns the raw dividend kept in acc_q
      fix_res = divz_q ?
        {acc_q[WIDTH-1:0], {WIDTH{1'b1}}} :
        {rem_s, quo_s};
    end else if (md_madd(op_q)) begin
      fix_res = acc_q + prod_s;
    end else if (md_msub(op_q)) begin
      fix_res = acc_q - prod_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    div_en   = 1'b0;
    if (bus.cancel_i && state_q != MD_ST_IDLE) begin
      state_d = MD_ST_IDLE;
      busy_d  = 1'b0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        MD_ST_IDLE, MD_ST_DONE: begin
          state_d = MD_ST_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b0;
          if (accept) begin
            op_d     = in_op;
            neg_d    = s1 ^ s2;
            rneg_d   = s1;
            divz_d   = in_dz;
            dbz_d    = 1'b0;
            acc_d    = in_div ?
              {{WIDTH{1'b0}}, bus.opdata1_i} : bus.acc_i;
            mcand_d  = {{WIDTH{1'b0}}, mag1};
            mplier_d = mag2;
            prod_d   = '0;
            busy_d   = 1'b1;
            if (in_dz) begin
              state_d = MD_ST_FIX;
            end else if (in_div) begin
              state_d = MD_ST_DIV;
              cnt_d   = DIV_LAST;
            end else begin
              state_d = MD_ST_MUL;
              cnt_d   = MUL_LAST;
            end
          end
        end
        MD_ST_MUL: begin
          prod_d   = prod_q + mcand_q *
                     DW'(mplier_q[MUL_BITS-1:0]);
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = MD_ST_FIX;
        end
        MD_ST_DIV: begin
          div_en = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = MD_ST_FIX;
        end
        MD_ST_FIX: begin
          state_d  = MD_ST_DONE;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          result_d = fix_res;
          dbz_d    = divz_q;
        end
        default: begin
          state_d = MD_ST_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_ST_IDLE;
      op_q     <= MD_OP_MULT;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.ready_o       = ready_q;
  assign bus.result_o      = result_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32,
// MUL_BITS=8): directed cases plus random ops.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic        dz;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .MUL_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] model(md_op_e op,
    logic [31:0] a, logic [31:0] b, logic [63:0] acc);
    longint sa, sb2, p, qv, rv;
    logic sg;
    sg  = op inside {MD_OP_MULT, MD_OP_DIV,
                     MD_OP_MADD, MD_OP_MSUB};
    sa  = sg ? longint'($signed(a)) : longint'({32'h0, a});
    sb2 = sg ? longint'($signed(b)) : longint'({32'h0, b});
    p   = sa * sb2;
    case (op)
      MD_OP_DIV, MD_OP_DIVU: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        qv = sa / sb2;
        rv = sa % sb2;
        return {1'b0, rv[31:0], qv[31:0]};
      end
      MD_OP_MADD, MD_OP_MADDU: return {1'b0, acc + p};
      MD_OP_MSUB, MD_OP_MSUBU: return {1'b0, acc - p};
      default: return {1'b0, p};
    endcase
  endfunction

  // called at a negedge; returns at the negedge of cycle 1
  task automatic issue(string tag, md_op_e op,
    logic [31:0] a, logic [31:0] b, logic [63:0] acc,
    logic [63:0] res, logic dz, int lat, bit push);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.acc_i     = acc;
    if (push)
      sb.push_back('{tag: tag, res: res, dz: dz,
                     at: edges + lat});
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.op_i      = md_op_e'(3'($urandom));
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    bus.acc_i     = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++)
      @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ready_o) begin
      if (sb.size() == 0) begin
        chk("unexp_ready", 64'(bus.ready_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_lat"}, 64'(edges), 64'(mon_e.at));
        chk({mon_e.tag, "_res"}, bus.result_o, mon_e.res);
        chk({mon_e.tag, "_dz"}, 64'(bus.div_by_zero_o),
            64'(mon_e.dz));
      end
    end
  end

  initial begin
    int e0;
    md_op_e op;
    logic [31:0] a, b;
    logic [63:0] acc;
    logic [64:0] m;
    bus.start_i   = 1'b0;
    bus.cancel_i  = 1'b0;
    bus.op_i      = MD_OP_MULT;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.acc_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_dz", 64'(bus.div_by_zero_o), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue("mult", MD_OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0,
          64'hFFFFFFFF_FFFFFFF1, 1'b0, 6, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("mult_busy%0d", c),
          64'(bus.busy_o), 64'd1);
      if (c == 3) begin
        bus.start_i   = 1'b1;
        bus.op_i      = MD_OP_DIVU;
        bus.opdata1_i = 32'd1;
        bus.opdata2_i = 32'd1;
      end
      if (c == 4) bus.start_i = 1'b0;
      @(negedge clk);
    end
    chk("mult_busy6", 64'(bus.busy_o), 64'd0);
    chk("mult_ready6", 64'(bus.ready_o), 64'd1);
    issue("div_b2b", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0,
          64'hFFFFFFFF_FFFFFFFD, 1'b0, 34, 1'b1);
    wait_idle();

    issue("divu_z", MD_OP_DIVU, 32'h80000000, 32'd0, 64'd0,
          64'h80000000_FFFFFFFF, 1'b1, 2, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("dz_hold", 64'(bus.div_by_zero_o), 64'd1);
    issue("maddu", MD_OP_MADDU, 32'hFFFFFFFF, 32'd2,
          64'h00000001_FFFFFFFF, 64'h00000003_FFFFFFFD,
          1'b0, 6, 1'b1);
    chk("dz_clear", 64'(bus.div_by_zero_o), 64'd0);
    wait_idle();
    issue("msub", MD_OP_MSUB, 32'h80000000, 32'h80000000,
          64'd0, 64'hC0000000_00000000, 1'b0, 6, 1'b1);
    wait_idle();
    @(negedge clk);

    e0 = edges;
    issue("divu_cx", MD_OP_DIVU, 32'd100, 32'd7, 64'd0,
          64'd0, 1'b0, 34, 1'b0);
    for (int i = 0; i < 20 && edges < e0 + 10; i++)
      @(negedge clk);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    bus.cancel_i = 1'b0;
    chk("cx_cycle", 64'(edges - e0), 64'd11);
    chk("cx_busy", 64'(bus.busy_o), 64'd0);
    chk("cx_hold", bus.result_o, 64'hC0000000_00000000);
    issue("multu", MD_OP_MULTU, 32'd3, 32'd4, 64'd0,
          64'd12, 1'b0, 6, 1'b1);
    wait_idle();
    @(negedge clk);

    bus.start_i  = 1'b1;
    bus.cancel_i = 1'b1;
    bus.op_i     = MD_OP_MULTU;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    chk("cx_start_busy", 64'(bus.busy_o), 64'd0);

    issue("rst_mid", MD_OP_MULT, 32'd9, 32'd9, 64'd0,
          64'd0, 1'b0, 6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_busy", 64'(bus.busy_o), 64'd0);
    chk("rmid_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      op  = md_op_e'(3'($urandom));
      a   = ($urandom_range(3) == 0) ? 32'h80000000 : $urandom;
      b   = $urandom;
      if ($urandom_range(4) == 0) b = 32'd0;
      else if ($urandom_range(2) == 0) b = $urandom_range(1, 9);
      acc = {$urandom, $urandom};
      m   = model(op, a, b, acc);
      issue($sformatf("rnd%0d_%s", n, op.name()), op, a, b,
            acc, m[63:0], m[64],
            md_div(op) ? ((b == 0) ? 2 : 34) : 6, 1'b1);
      wait_idle();
    end

    wait_idle();
    chk("drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
